// File: rtl/acc_dispatcher.sv
// Routes buffered core accelerator commands to one of NR_ACC accelerators, gated by an
// rd scoreboard and per-accelerator outstanding limits; round-robin merges responses back.
module acc_dispatcher #(
  parameter int NR_ACC             = 2,
  parameter int ACC_DATA_WIDTH     = 64,
  parameter int ACC_INSTR_WIDTH    = 32,
  parameter int ACC_REG_ADDR_WIDTH = 5,
  parameter int MAX_OUTSTANDING    = 2,
  parameter int SEL_LSB            = 25
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  // core command channel
  input  logic                                   core_cmd_valid_i,
  output logic                                   core_cmd_ready_o,
  input  logic [ACC_INSTR_WIDTH-1:0]             core_cmd_instr_i,
  input  logic [ACC_DATA_WIDTH-1:0]              core_cmd_rs1_i,
  input  logic [ACC_DATA_WIDTH-1:0]              core_cmd_rs2_i,
  // accelerator command channels
  output logic [NR_ACC-1:0]                      acc_cmd_valid_o,
  input  logic [NR_ACC-1:0]                      acc_cmd_ready_i,
  output logic [ACC_INSTR_WIDTH-1:0]             acc_cmd_instr_o,
  output logic [ACC_DATA_WIDTH-1:0]              acc_cmd_rs1_o,
  output logic [ACC_DATA_WIDTH-1:0]              acc_cmd_rs2_o,
  // accelerator response channels
  input  logic [NR_ACC-1:0]                      acc_resp_valid_i,
  output logic [NR_ACC-1:0]                      acc_resp_ready_o,
  input  logic [NR_ACC*ACC_DATA_WIDTH-1:0]       acc_resp_data_i,
  input  logic [NR_ACC*ACC_REG_ADDR_WIDTH-1:0]   acc_resp_rd_i,
  // core response channel
  output logic                                   core_resp_valid_o,
  input  logic                                   core_resp_ready_i,
  output logic [ACC_DATA_WIDTH-1:0]              core_resp_data_o,
  output logic [ACC_REG_ADDR_WIDTH-1:0]          core_resp_rd_o,
  // status
  output logic                                   illegal_o,
  output logic                                   idle_o
);

  localparam int SEL_W   = (NR_ACC > 2) ? $clog2(NR_ACC) : 1;
  localparam int NR_SEL  = 2 ** SEL_W;
  localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int NR_REGS = 2 ** ACC_REG_ADDR_WIDTH;

  typedef logic [SEL_W-1:0]              sel_t;
  typedef logic [CNT_W-1:0]              cnt_t;
  typedef logic [ACC_REG_ADDR_WIDTH-1:0] rd_t;
  typedef logic [ACC_DATA_WIDTH-1:0]     data_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                       buf_valid_q;
  logic [ACC_INSTR_WIDTH-1:0] buf_instr_q;
  data_t                      buf_rs1_q, buf_rs2_q;

  cnt_t                       cnt_q [NR_ACC];
  cnt_t                       cnt_d [NR_ACC];
  logic [NR_REGS-1:0]         busy_q, busy_d;
  sel_t                       rr_ptr_q, rr_ptr_d;

  logic                       resp_valid_q;
  data_t                      resp_data_q;
  rd_t                        resp_rd_q;

  // ---------------------------------------------------------------------------
  // Command path
  // ---------------------------------------------------------------------------
  sel_t              tgt;
  rd_t               buf_rd;
  logic [NR_SEL-1:0] legal_vec;
  logic              tgt_legal;
  cnt_t              cnt_sel;
  logic              dispatch_ok;
  logic              cmd_fire;
  logic              illegal;
  logic              buf_leave;
  logic              cmd_accept;

  assign tgt    = buf_instr_q[SEL_LSB +: SEL_W];
  assign buf_rd = buf_instr_q[7 +: ACC_REG_ADDR_WIDTH];

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    legal_vec = '0;
    for (int i = 0; i < NR_SEL; i++) legal_vec[i] = (i < NR_ACC);
  end

  assign tgt_legal = legal_vec[tgt];

  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < NR_ACC; i++) begin
      if (tgt == sel_t'(i)) cnt_sel = cnt_q[i];
    end
  end

  // Scoreboard and counters are read from registered state only, so a response
  // clearing a hazard unblocks dispatch one cycle later, never combinationally.
  assign dispatch_ok = buf_valid_q && tgt_legal
                    && (cnt_sel < cnt_t'(MAX_OUTSTANDING))
                    && !((buf_rd != '0) && busy_q[buf_rd]);

  always_comb begin
    acc_cmd_valid_o = '0;
    for (int i = 0; i < NR_ACC; i++) acc_cmd_valid_o[i] = dispatch_ok && (tgt == sel_t'(i));
  end

  assign cmd_fire         = |(acc_cmd_valid_o & acc_cmd_ready_i);
  assign illegal          = buf_valid_q && !tgt_legal;
  assign buf_leave        = cmd_fire || illegal;
  assign core_cmd_ready_o = !buf_valid_q || buf_leave;
  assign cmd_accept       = core_cmd_valid_i && core_cmd_ready_o;

  assign acc_cmd_instr_o = buf_instr_q;
  assign acc_cmd_rs1_o   = buf_rs1_q;
  assign acc_cmd_rs2_o   = buf_rs2_q;
  assign illegal_o       = illegal;

  // NOTE: sequential state is assigned with <= so all registers update together
  // from pre-edge values regardless of statement order.
  // NOTE: buffer payload is reset too, because it drives the broadcast data
  // outputs directly and those must read 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_valid_q <= 1'b0;
      buf_instr_q <= '0;
      buf_rs1_q   <= '0;
      buf_rs2_q   <= '0;
    end else if (cmd_accept) begin
      buf_valid_q <= 1'b1;
      buf_instr_q <= core_cmd_instr_i;
      buf_rs1_q   <= core_cmd_rs1_i;
      buf_rs2_q   <= core_cmd_rs2_i;
    end else if (buf_leave) begin
      buf_valid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Response arbiter
  // ---------------------------------------------------------------------------
  logic  resp_eligible;
  logic  resp_found;
  logic  resp_fire;
  int    grant_int;
  int    idx;
  sel_t  grant_idx;
  data_t resp_data_sel;
  rd_t   resp_rd_sel;

  assign resp_eligible = !resp_valid_q || core_resp_ready_i;

  always_comb begin
    resp_found       = 1'b0;
    grant_int        = 0;
    idx              = 0;
    resp_data_sel    = '0;
    resp_rd_sel      = '0;
    acc_resp_ready_o = '0;
    for (int k = 0; k < NR_ACC; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NR_ACC) idx = idx - NR_ACC;
      if (!resp_found && acc_resp_valid_i[idx]) begin
        resp_found    = 1'b1;
        grant_int     = idx;
        resp_data_sel = acc_resp_data_i[idx*ACC_DATA_WIDTH +: ACC_DATA_WIDTH];
        resp_rd_sel   = acc_resp_rd_i[idx*ACC_REG_ADDR_WIDTH +: ACC_REG_ADDR_WIDTH];
      end
    end
    if (resp_eligible && resp_found) acc_resp_ready_o[grant_int] = 1'b1;
  end

  assign resp_fire = resp_eligible && resp_found;
  assign grant_idx = sel_t'(grant_int);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (resp_fire) rr_ptr_d = (grant_idx == sel_t'(NR_ACC - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
    end else if (resp_fire) begin
      resp_valid_q <= 1'b1;
      resp_data_q  <= resp_data_sel;
      resp_rd_q    <= resp_rd_sel;
    end else if (core_resp_ready_i) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign core_resp_valid_o = resp_valid_q;
  assign core_resp_data_o  = resp_data_q;
  assign core_resp_rd_o    = resp_rd_q;

  // ---------------------------------------------------------------------------
  // Outstanding counters and rd scoreboard
  // ---------------------------------------------------------------------------
  logic cnt_inc, cnt_dec, cnt_all_zero;

  always_comb begin
    cnt_inc      = 1'b0;
    cnt_dec      = 1'b0;
    cnt_all_zero = 1'b1;
    for (int i = 0; i < NR_ACC; i++) begin
      cnt_d[i] = cnt_q[i];
      cnt_inc  = acc_cmd_valid_o[i] && acc_cmd_ready_i[i];
      cnt_dec  = resp_fire && (grant_idx == sel_t'(i));
      // A dispatch and a response on the same accelerator cancel out.
      if (cnt_inc && !cnt_dec)                         cnt_d[i] = cnt_q[i] + cnt_t'(1);
      else if (cnt_dec && !cnt_inc && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - cnt_t'(1);
      if (cnt_q[i] != '0) cnt_all_zero = 1'b0;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (resp_fire && resp_rd_sel != '0) busy_d[resp_rd_sel] = 1'b0;
    // Applied after the clear so a same-cycle set on the same rd wins.
    if (cmd_fire && buf_rd != '0)       busy_d[buf_rd]      = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ACC; i++) cnt_q[i] <= '0;
      busy_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      for (int i = 0; i < NR_ACC; i++) cnt_q[i] <= cnt_d[i];
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign idle_o = !buf_valid_q && !resp_valid_q && cnt_all_zero;

endmodule
